// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 register bridge: the FSM state type,
// the wait-counter limits and a helper for sizing the register index.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_CYCLES_MAX = 15;
    localparam int CNT_W           = 4;

    // A bank of one register still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of a captured APB address: range, alignment and
// read-only checks, plus the word index presented to the register bank.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int                    ADDR_W   = 12,
    parameter int                    DATA_W   = 32,
    parameter int                    NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = '0,
    parameter int                    IDX_W    = idx_width(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    output logic              err,
    output logic [IDX_W-1:0]  idx
);

    localparam int          BYTES    = DATA_W / 8;
    localparam int          LSB      = $clog2(BYTES);
    localparam logic [63:0] LIMIT    = 64'(NUM_REGS * BYTES);
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(BYTES - 1);

    logic                in_range;
    logic                aligned;
    logic                valid;
    logic                ro_hit;
    logic [NUM_REGS-1:0] ro_bits;

    assign in_range = 64'(addr) < LIMIT;
    assign aligned  = (addr & LSB_MASK) == '0;
    assign valid    = in_range && aligned;
    assign idx      = IDX_W'(addr >> LSB);

    // Only consulted when the address is valid, so idx is always in range here.
    assign ro_bits  = RO_MASK >> idx;
    assign ro_hit   = valid && write && ro_bits[0];
    assign err      = !valid || ro_hit;

endmodule

// File: rtl/apb4_reg_bridge.sv
// APB4 slave that turns transfers into single-cycle strobes on a simple
// register bank, with programmable wait states and an error counter.
module apb4_reg_bridge
    import apb_pkg::*;
#(
    parameter int                    ADDR_W      = 12,
    parameter int                    DATA_W      = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    localparam int                   IDX_W       = idx_width(NUM_REGS),
    localparam int                   STRB_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [STRB_W-1:0] PSTRB,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] PRDATA,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [STRB_W-1:0] reg_wstrb,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [7:0]        err_cnt
);

    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES);

    state_t             state_reg,   state_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [ADDR_W-1:0]  addr_reg,    addr_next;
    logic               write_reg,   write_next;
    logic [DATA_W-1:0]  wdata_reg,   wdata_next;
    logic [STRB_W-1:0]  strb_reg,    strb_next;
    logic [7:0]         err_cnt_reg, err_cnt_next;

    logic               capture;
    logic               in_resp;
    logic               dec_err;
    logic [IDX_W-1:0]   dec_idx;

    apb_addr_decode #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .IDX_W    (IDX_W)
    ) u_decode (
        .addr  (addr_reg),
        .write (write_reg),
        .err   (dec_err),
        .idx   (dec_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            wdata_reg   <= '0;
            strb_reg    <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            wdata_reg   <= wdata_next;
            strb_reg    <= strb_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        write_next   = write_reg;
        wdata_next   = wdata_reg;
        strb_next    = strb_reg;
        err_cnt_next = err_cnt_reg;
        capture      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next = ST_WAIT;
                    capture    = 1'b1;
                end
            end
            ST_WAIT: begin
                // Losing PSEL mid-transfer is a master abort: drop it silently.
                if (!PSEL) begin
                    state_next = ST_IDLE;
                end else if (PENABLE) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (PSEL && !PENABLE) begin
                    state_next = ST_WAIT;
                    capture    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
                if (dec_err && (err_cnt_reg != 8'hFF)) begin
                    err_cnt_next = err_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (capture) begin
            addr_next  = PADDR;
            write_next = PWRITE;
            wdata_next = PWDATA;
            strb_next  = PSTRB;
            cnt_next   = WAIT_LOAD;
        end
    end

    assign in_resp   = (state_reg == ST_RESP);
    assign PREADY    = in_resp;
    assign PSLVERR   = in_resp && dec_err;
    assign reg_wr_en = in_resp && write_reg && !dec_err;
    assign reg_rd_en = in_resp && !write_reg && !dec_err;
    assign PRDATA    = reg_rd_en ? reg_rdata : '0;
    assign reg_idx   = dec_idx;
    assign reg_wdata = wdata_reg;
    assign reg_wstrb = strb_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
